// File: rtl/prj_definition.sv
// Shared definitions for the memory arbiter: bus widths, index limits and FSM encodings.
package prj_definition;

  localparam int DATA_WIDTH        = 32;
  localparam int ADDRESS_WIDTH     = 26;
  localparam int DATA_INDEX_MSB    = DATA_WIDTH - 1;
  localparam int ADDRESS_INDEX_MSB = ADDRESS_WIDTH - 1;
  localparam int WAIT_CNT_WIDTH    = 4;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE   = 2'b00,
    MEM_ARB_ACCESS = 2'b01,
    MEM_ARB_ACK    = 2'b10
  } mem_arb_state_e;

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// Two-requester winner selection; ptr=0 favours M0 on a tie, ptr=1 favours M1.
module arb_priority (
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       ptr,
  output logic [1:0] winner
);

  // one-hot winner from the request pair and the tie-break pointer
  always_comb begin
    winner = 2'b00;
    if (REQ0 && REQ1) begin
      winner = ptr ? 2'b10 : 2'b01;
    end else if (REQ0) begin
      winner = 2'b01;
    end else if (REQ1) begin
      winner = 2'b10;
    end else begin
      winner = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter (IDLE -> ACCESS -> ACK). Define MEM_ARB_ROUND_ROBIN_EN for
// round-robin tie-break; otherwise M0 always wins ties.
module mem_arbiter
  import prj_definition::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ0,
  input  logic                         REQ1,
  input  logic                         WE0,
  input  logic                         WE1,
  input  logic [ADDRESS_INDEX_MSB:0]   ADDR0,
  input  logic [ADDRESS_INDEX_MSB:0]   ADDR1,
  input  logic [DATA_INDEX_MSB:0]      WDATA0,
  input  logic [DATA_INDEX_MSB:0]      WDATA1,
  output logic                         GNT0,
  output logic                         GNT1,
  output logic                         ACK0,
  output logic                         ACK1,
  output logic [DATA_INDEX_MSB:0]      RDATA,
  output logic [ADDRESS_INDEX_MSB:0]   MEM_ADDR,
  output logic                         MEM_READ,
  output logic                         MEM_WRITE,
  inout  wire  [DATA_INDEX_MSB:0]      MEM_DATA
);

  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES - 1);

  mem_arb_state_e              state_r, state_next_s;
  logic [1:0]                  winner_s;
  logic                        ptr_s;
  logic                        owner_r;
  logic                        we_r;
  logic [ADDRESS_INDEX_MSB:0]  addr_r;
  logic [DATA_INDEX_MSB:0]     wdata_r;
  logic [1:0]                  gnt_r;
  logic [1:0]                  ack_r;
  logic [WAIT_CNT_WIDTH-1:0]   cnt_r;
  logic                        busy_r;
  logic [DATA_INDEX_MSB:0]     rdata_r;
  logic [ADDRESS_INDEX_MSB:0]  mem_addr_r;
  logic                        mem_read_r;
  logic                        mem_write_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_r;

  // tie-break pointer hands priority to the requester not served last
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr_r <= 1'b0;
    end else if (state_r == MEM_ARB_ACK) begin
      ptr_r <= ~owner_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = 1'b0;
`endif

  arb_priority u_arb_priority (
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .ptr    (ptr_s),
    .winner (winner_s)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= MEM_ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state; the first ACCESS cycle (busy_r low) sets up the memory controls
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MEM_ARB_IDLE:   state_next_s = (winner_s != 2'b00) ? MEM_ARB_ACCESS : MEM_ARB_IDLE;
      MEM_ARB_ACCESS: state_next_s = (busy_r && (cnt_r == '0)) ? MEM_ARB_ACK : MEM_ARB_ACCESS;
      MEM_ARB_ACK:    state_next_s = MEM_ARB_IDLE;
      default:        state_next_s = MEM_ARB_IDLE;
    endcase
  end

  // operand latch, wait counter and registered memory/handshake outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      gnt_r       <= 2'b00;
      ack_r       <= 2'b00;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      rdata_r     <= '0;
      mem_addr_r  <= '0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      case (state_r)
        MEM_ARB_IDLE: begin
          ack_r <= 2'b00;
          gnt_r <= winner_s;
          if (winner_s != 2'b00) begin
            owner_r <= winner_s[1];
            we_r    <= winner_s[1] ? WE1 : WE0;
            addr_r  <= winner_s[1] ? ADDR1 : ADDR0;
            wdata_r <= winner_s[1] ? WDATA1 : WDATA0;
            cnt_r   <= CNT_LOAD;
          end
        end
        MEM_ARB_ACCESS: begin
          if (!busy_r) begin
            busy_r      <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_read_r  <= ~we_r;
            mem_write_r <= we_r;
          end else if (cnt_r == '0) begin
            busy_r      <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            ack_r       <= owner_r ? 2'b10 : 2'b01;
            if (!we_r) begin
              rdata_r <= MEM_DATA;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        MEM_ARB_ACK: begin
          ack_r <= 2'b00;
          gnt_r <= 2'b00;
        end
        default: begin
          ack_r       <= 2'b00;
          gnt_r       <= 2'b00;
          busy_r      <= 1'b0;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign GNT0      = gnt_r[0];
  assign GNT1      = gnt_r[1];
  assign ACK0      = ack_r[0];
  assign ACK1      = ack_r[1];
  assign RDATA     = rdata_r;
  assign MEM_ADDR  = mem_addr_r;
  assign MEM_READ  = mem_read_r;
  assign MEM_WRITE = mem_write_r;
  assign MEM_DATA  = (mem_write_r && !mem_read_r) ? wdata_r : {DATA_WIDTH{1'bz}};

endmodule
